// File: rtl/player_motion_ctl.sv
// -----------------------------------------------------------------------------
// player_motion_ctl
//
// Frame-stepped player position controller. Horizontal motion is a small
// IDLE/RIGHT/LEFT FSM that walks the player STEP pixels per frame. Closed gate
// regions stop entry at their edges. A separate jump/gravity axis drives y.
// State changes only on a frame step, which is the rising edge of v_tick.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   v_tick       in   frame strobe (level); rising edge = one frame step
//   m_left       in   move-left request (level)
//   m_right      in   move-right request (level)
//   m_jump       in   jump request (level)
//   gate_open    in   [N_GATES] bit i high = gate i passable
//   xpos_player  out  [XW] player x (0..X_MAX)
//   ypos_player  out  [XW] player y (0..Y_GROUND, smaller = higher)
//   airborne     out  player is in a jump
//   blocked      out  move requested this frame but x did not change
// -----------------------------------------------------------------------------
module player_motion_ctl #(
   parameter int                     XW       = 12,
   parameter int                     X_START  = 0,
   parameter int                     X_MAX    = 1056,
   parameter int                     STEP     = 1,
   parameter int                     N_GATES  = 2,
   parameter logic [N_GATES*XW-1:0]  GATE_LO  = {12'd700, 12'd350},
   parameter logic [N_GATES*XW-1:0]  GATE_HI  = {12'd800, 12'd450},
   parameter int                     Y_GROUND = 600,
   parameter int                     JUMP_V0  = 8,
   parameter int                     GRAVITY  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               v_tick,
   input  logic               m_left,
   input  logic               m_right,
   input  logic               m_jump,
   input  logic [N_GATES-1:0] gate_open,
   output logic [XW-1:0]      xpos_player,
   output logic [XW-1:0]      ypos_player,
   output logic               airborne,
   output logic               blocked
);

   // Two extra bits keep x+STEP, x-STEP and y-vy free of wrap-around.
   localparam int SW = XW + 2;

   localparam logic signed [SW-1:0] C_XMAX_S = SW'(X_MAX);
   localparam logic signed [SW-1:0] C_STEP_S = SW'(STEP);
   localparam logic signed [SW-1:0] C_YGND_S = SW'(Y_GROUND);
   localparam logic signed [SW-1:0] C_V0_S   = SW'(JUMP_V0);
   localparam logic signed [SW-1:0] C_GRAV_S = SW'(GRAVITY);
   localparam logic [XW-1:0]        C_XMAX   = XW'(X_MAX);
   localparam logic [XW-1:0]        C_XSTART = XW'(X_START);
   localparam logic [XW-1:0]        C_YGND   = XW'(Y_GROUND);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RIGHT = 2'd1,
      ST_LEFT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------- registers
   logic                 r_vtick_d;
   state_t               r_state;
   logic [XW-1:0]        r_x;
   logic [XW-1:0]        r_y;
   logic signed [SW-1:0] r_vy;
   logic                 r_air;
   logic                 r_blocked;

   // --------------------------------------------------------------- next state
   state_t               w_state_next;
   logic [XW-1:0]        w_x_next;
   logic [XW-1:0]        w_y_next;
   logic signed [SW-1:0] w_vy_next;
   logic                 w_air_next;
   logic                 w_blocked_next;

   logic                 w_frame;
   logic                 w_req_r;
   logic                 w_req_l;

   // --------------------------------------------------------- target compute
   logic signed [SW-1:0] w_x_ext;
   logic signed [SW-1:0] w_rsum;
   logic signed [SW-1:0] w_lsum;
   logic [XW-1:0]        w_tr_base;
   logic [XW-1:0]        w_tl_base;
   logic [XW-1:0]        w_tr;
   logic [XW-1:0]        w_tl;
   logic [XW-1:0]        w_lo [N_GATES];
   logic [XW-1:0]        w_hi [N_GATES];
   logic [N_GATES-1:0]   w_hit_r;
   logic [N_GATES-1:0]   w_hit_l;
   logic signed [SW-1:0] w_ydiff;

   // The delayed copy resets high so a v_tick held through reset release
   // does not count as a frame.
   assign w_frame = v_tick & ~r_vtick_d;
   assign w_req_r = m_right & ~m_left;
   assign w_req_l = m_left & ~m_right;

   assign w_x_ext   = $signed({2'b00, r_x});
   assign w_rsum    = w_x_ext + C_STEP_S;
   assign w_lsum    = w_x_ext - C_STEP_S;
   assign w_tr_base = (w_rsum > C_XMAX_S) ? C_XMAX : w_rsum[XW-1:0];
   assign w_tl_base = (w_lsum < 0) ? '0 : w_lsum[XW-1:0];

   // A closed gate only clamps motion that would cross its near edge; a
   // player already inside (gate closed behind them) is free to walk out.
   genvar gi;
   generate
      for (gi = 0; gi < N_GATES; gi++) begin : g_gate
         assign w_lo[gi]    = GATE_LO[gi*XW +: XW];
         assign w_hi[gi]    = GATE_HI[gi*XW +: XW];
         assign w_hit_r[gi] = ~gate_open[gi] & (r_x <= w_lo[gi]) & (w_lo[gi] < w_tr_base);
         assign w_hit_l[gi] = ~gate_open[gi] & (w_tl_base < w_hi[gi]) & (w_hi[gi] <= r_x);
      end
   endgenerate

   // Nearest blocking edge wins: smallest LO going right, largest HI going left.
   always_comb begin
      w_tr = w_tr_base;
      w_tl = w_tl_base;
      for (int i = 0; i < N_GATES; i++) begin
         if (w_hit_r[i] && (w_lo[i] < w_tr)) w_tr = w_lo[i];
         if (w_hit_l[i] && (w_hi[i] > w_tl)) w_tl = w_hi[i];
      end
   end

   // ------------------------------------------------------- horizontal FSM
   always_comb begin
      w_state_next   = r_state;
      w_x_next       = r_x;
      w_blocked_next = r_blocked;
      if (w_frame) begin
         w_blocked_next = 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Entering a direction moves nothing this frame.
               if (w_req_r)      w_state_next = ST_RIGHT;
               else if (w_req_l) w_state_next = ST_LEFT;
            end
            ST_RIGHT: begin
               if (w_req_r) begin
                  w_x_next       = w_tr;
                  w_blocked_next = (w_tr == r_x);
                  w_state_next   = (w_tr < C_XMAX) ? ST_RIGHT : ST_IDLE;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
            ST_LEFT: begin
               if (w_req_l) begin
                  w_x_next       = w_tl;
                  w_blocked_next = (w_tl == r_x);
                  w_state_next   = (w_tl != '0) ? ST_LEFT : ST_IDLE;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- vertical axis
   assign w_ydiff = $signed({2'b00, r_y}) - r_vy;

   always_comb begin
      w_y_next   = r_y;
      w_vy_next  = r_vy;
      w_air_next = r_air;
      if (w_frame) begin
         if (!r_air) begin
            // Launch frame: speed is loaded, y moves from the next frame on.
            if (m_jump) begin
               w_air_next = 1'b1;
               w_vy_next  = C_V0_S;
            end
         end else if (w_ydiff >= C_YGND_S) begin
            w_y_next   = C_YGND;
            w_vy_next  = '0;
            w_air_next = 1'b0;
         end else if (w_ydiff < 0) begin
            w_y_next  = '0;
            w_vy_next = '0;
         end else begin
            w_y_next  = w_ydiff[XW-1:0];
            w_vy_next = r_vy - C_GRAV_S;
         end
      end
   end

   // --------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vtick_d <= 1'b1;
         r_state   <= ST_IDLE;
         r_x       <= C_XSTART;
         r_y       <= C_YGND;
         r_vy      <= '0;
         r_air     <= 1'b0;
         r_blocked <= 1'b0;
      end else begin
         r_vtick_d <= v_tick;
         r_state   <= w_state_next;
         r_x       <= w_x_next;
         r_y       <= w_y_next;
         r_vy      <= w_vy_next;
         r_air     <= w_air_next;
         r_blocked <= w_blocked_next;
      end
   end

   assign xpos_player = r_x;
   assign ypos_player = r_y;
   assign airborne    = r_air;
   assign blocked     = r_blocked;

endmodule

// File: tb/tb_player_motion_ctl.sv
// Bench for player_motion_ctl: directed scenarios with literal expectations,
// then randomized stimulus; every cycle the DUT is compared with a frame-level
// behavioural model of the player.
module tb_player_motion_ctl;

   localparam int X_MAX    = 1056;
   localparam int STEP     = 1;
   localparam int Y_GROUND = 600;
   localparam int JUMP_V0  = 8;
   localparam int GRAVITY  = 1;

   int lo_tab [2] = '{350, 700};
   int hi_tab [2] = '{450, 800};
   int ytab  [16] = '{592, 585, 579, 574, 570, 567, 565, 564,
                      564, 565, 567, 570, 574, 579, 585, 592};

   logic        clk;
   logic        rst_n;
   logic        v_tick;
   logic        m_left;
   logic        m_right;
   logic        m_jump;
   logic [1:0]  gate_open;
   logic [11:0] xpos_player;
   logic [11:0] ypos_player;
   logic        airborne;
   logic        blocked;

   player_motion_ctl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .v_tick      (v_tick),
      .m_left      (m_left),
      .m_right     (m_right),
      .m_jump      (m_jump),
      .gate_open   (gate_open),
      .xpos_player (xpos_player),
      .ypos_player (ypos_player),
      .airborne    (airborne),
      .blocked     (blocked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Behavioural model: position, speed, direction of travel (+1/-1/0 = none)
   int md_x, md_y, md_vy, md_dir;
   bit md_air, md_blk, md_prev;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   // Literal expectation pinned on both the DUT and the model.
   task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
      chk(nm, dut_v, exp);
      chk({nm, "_model"}, mdl_v, exp);
   endtask

   task automatic model_reset();
      md_x = 0; md_y = Y_GROUND; md_vy = 0; md_dir = 0;
      md_air = 0; md_blk = 0; md_prev = 1;
   endtask

   task automatic model_step();
      bit frame;
      int t;
      int nd;
      if (!rst_n) begin
         model_reset();
         return;
      end
      frame   = v_tick && !md_prev;
      md_prev = v_tick;
      if (!frame) return;
      // horizontal: walk one STEP, stop at the nearest closed gate edge ahead
      if (md_dir == 0) begin
         md_blk = 0;
         if (m_right && !m_left)      md_dir = 1;
         else if (m_left && !m_right) md_dir = -1;
      end else if (md_dir == 1) begin
         if (m_right && !m_left) begin
            t = (md_x + STEP > X_MAX) ? X_MAX : md_x + STEP;
            for (int g = 0; g < 2; g++)
               if (!gate_open[g] && md_x <= lo_tab[g] && lo_tab[g] < t) t = lo_tab[g];
            md_blk = (t == md_x);
            md_x   = t;
            if (t == X_MAX) md_dir = 0;
         end else begin
            md_dir = 0; md_blk = 0;
         end
      end else begin
         if (m_left && !m_right) begin
            t = (md_x - STEP < 0) ? 0 : md_x - STEP;
            for (int g = 0; g < 2; g++)
               if (!gate_open[g] && t < hi_tab[g] && hi_tab[g] <= md_x) t = hi_tab[g];
            md_blk = (t == md_x);
            md_x   = t;
            if (t == 0) md_dir = 0;
         end else begin
            md_dir = 0; md_blk = 0;
         end
      end
      // vertical: ballistic arc with floor and ceiling
      if (!md_air) begin
         if (m_jump) begin
            md_air = 1; md_vy = JUMP_V0;
         end
      end else begin
         nd = md_y - md_vy;
         if (nd >= Y_GROUND) begin
            md_y = Y_GROUND; md_vy = 0; md_air = 0;
         end else if (nd < 0) begin
            md_y = 0; md_vy = 0;
         end else begin
            md_y = nd; md_vy = md_vy - GRAVITY;
         end
      end
   endtask

   task automatic check_all();
      chk("xpos", int'(xpos_player), md_x);
      chk("ypos", int'(ypos_player), md_y);
      chk("airborne", int'(airborne), int'(md_air));
      chk("blocked", int'(blocked), int'(md_blk));
   endtask

   // One clock: model sees the same inputs the DUT samples, outputs
   // compared on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // One frame: v_tick low two cycles then high two cycles.
   task automatic frame_cyc();
      v_tick = 1'b0;
      cyc(); cyc();
      v_tick = 1'b1;
      cyc(); cyc();
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
   endtask

   initial begin
      int guard;
      rst_n = 1'b1; v_tick = 1'b1;
      m_left = 1'b0; m_right = 1'b0; m_jump = 1'b0; gate_open = 2'b00;
      model_reset();

      // Reset with v_tick high, released while still high
      #2 rst_n = 1'b0;
      #1;
      check_all();
      lit("reset_x", int'(xpos_player), md_x, 0);
      lit("reset_y", int'(ypos_player), md_y, 600);
      repeat (3) cyc();
      rst_n = 1'b1;
      m_jump = 1'b1;
      repeat (10) cyc();
      lit("no_frame_air", int'(airborne), int'(md_air), 0);
      lit("no_frame_x", int'(xpos_player), md_x, 0);
      v_tick = 1'b0; cyc();
      v_tick = 1'b1; cyc();
      lit("first_edge_air", int'(airborne), int'(md_air), 1);
      m_jump = 1'b0;
      repeat (17) frame_cyc();
      lit("landed_air", int'(airborne), int'(md_air), 0);
      $display("phase reset/first-edge done x=%0d y=%0d", xpos_player, ypos_player);

      // Walk right into closed gate 0
      m_right = 1'b1;
      for (int f = 1; f <= 400; f++) begin
         frame_cyc();
         if (f == 1)   lit("f1_x", int'(xpos_player), md_x, 0);
         if (f == 351) begin
            lit("f351_x", int'(xpos_player), md_x, 350);
            lit("f351_blk", int'(blocked), int'(md_blk), 0);
         end
         if (f == 352) lit("f352_blk", int'(blocked), int'(md_blk), 1);
      end
      lit("f400_x", int'(xpos_player), md_x, 350);
      $display("phase right-to-gate0 done x=%0d blocked=%0d", xpos_player, blocked);

      // Open gate 0: stop at gate 1; open gate 1: reach X_MAX
      gate_open = 2'b01;
      repeat (360) frame_cyc();
      lit("gate1_x", int'(xpos_player), md_x, 700);
      lit("gate1_blk", int'(blocked), int'(md_blk), 1);
      gate_open = 2'b11;
      repeat (370) frame_cyc();
      lit("xmax_x", int'(xpos_player), md_x, 1056);
      $display("phase through-gates done x=%0d", xpos_player);

      // Back to x=500, then left into closed gate 0
      m_right = 1'b0;
      frame_cyc();
      m_left = 1'b1;
      guard = 0;
      while (md_x > 500 && guard < 3000) begin
         frame_cyc();
         guard++;
      end
      m_left = 1'b0;
      frame_cyc();
      lit("at500_x", int'(xpos_player), md_x, 500);
      gate_open = 2'b10;
      m_left = 1'b1;
      repeat (60) frame_cyc();
      lit("left_gate_x", int'(xpos_player), md_x, 450);
      lit("left_gate_blk", int'(blocked), int'(md_blk), 1);
      $display("phase left-to-gate0 done x=%0d blocked=%0d", xpos_player, blocked);

      // Both directions held while idle
      m_left = 1'b0;
      frame_cyc();
      m_left = 1'b1; m_right = 1'b1;
      repeat (5) frame_cyc();
      lit("both_x", int'(xpos_player), md_x, 450);
      lit("both_blk", int'(blocked), int'(md_blk), 0);

      // Jump while walking right
      m_left = 1'b0; m_right = 1'b1; gate_open = 2'b11; m_jump = 1'b1;
      frame_cyc();
      lit("jump0_air", int'(airborne), int'(md_air), 1);
      lit("jump0_y", int'(ypos_player), md_y, 600);
      m_jump = 1'b0;
      for (int k = 0; k < 16; k++) begin
         frame_cyc();
         lit($sformatf("jump%0d_y", k + 1), int'(ypos_player), md_y, ytab[k]);
      end
      frame_cyc();
      lit("jump17_y", int'(ypos_player), md_y, 600);
      lit("jump17_air", int'(airborne), int'(md_air), 0);
      lit("jump17_x", int'(xpos_player), md_x, 467);
      $display("phase jump done x=%0d y=%0d", xpos_player, ypos_player);

      // Reset in the middle of a jump
      m_jump = 1'b1;
      frame_cyc();
      m_jump = 1'b0;
      frame_cyc(); frame_cyc();
      lit("midjump_air", int'(airborne), int'(md_air), 1);
      async_reset();
      lit("rst_mid_y", int'(ypos_player), md_y, 600);
      lit("rst_mid_air", int'(airborne), int'(md_air), 0);
      lit("rst_mid_x", int'(xpos_player), md_x, 0);
      cyc();
      rst_n = 1'b1;

      // Randomized stimulus
      m_left = 1'b0; m_right = 1'b1; m_jump = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 999) == 0) begin
            async_reset();
            cyc();
            rst_n = 1'b1;
         end
         v_tick = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 23) == 0) m_left  = ~m_left;
         if ($urandom_range(0, 23) == 0) m_right = ~m_right;
         m_jump = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 63) == 0) gate_open = 2'($urandom_range(0, 3));
         cyc();
      end
      $display("phase random done x=%0d y=%0d", xpos_player, ypos_player);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
